// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// port indices, geometry and the address range test.
package dmem_arbiter_pkg;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = 4;
  localparam int unsigned NPORTS    = 2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // A word access touches addr..addr+3, so the last legal address is MEM_BYTES-4.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr);
    return addr > ADDR_W'(MEM_BYTES - 4);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester handshake signals and the memory-side bus of the arbiter.
// slave = the arbiter, master = requesters plus memory model.
interface dmem_if;
  import dmem_arbiter_pkg::*;

  logic [NPORTS-1:0]        req_valid;
  logic [NPORTS-1:0]        req_ready;
  logic [NPORTS-1:0]        req_we;
  logic [NPORTS*ADDR_W-1:0] req_addr;
  logic [NPORTS*DATA_W-1:0] req_wdata;
  logic [NPORTS*BE_W-1:0]   req_be;
  logic [NPORTS-1:0]        rsp_valid;
  logic [NPORTS-1:0]        rsp_ready;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     rsp_err;
  logic                     mem_read;
  logic                     mem_write;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_write_data;
  logic [BE_W-1:0]          mem_byte_enable;
  logic [DATA_W-1:0]        mem_data_out;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_addr, mem_write_data, mem_byte_enable
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_addr, mem_write_data, mem_byte_enable
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_valid_o = |valid_i;
    gnt_idx_o   = 1'b0;
    case (valid_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_grant_i;
      default: gnt_idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU (port 0) and DMA (port 1),
// one transaction at a time: IDLE -> ACCESS -> RESP, out-of-range skips ACCESS.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus,
  output state_e state_o
);

  // Handshakes: a request transfers on a cycle where req_valid[i] and req_ready[i]
  // are both high at posedge clk; a response transfers where rsp_valid[i] and
  // rsp_ready[i] are both high. Response payload is stable while rsp_valid waits.

  state_e              state_q, state_d;
  logic                last_grant_q;
  logic                owner_q;
  logic                we_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [BE_W-1:0]     be_q;

  logic                gnt_valid;
  logic                gnt_idx;
  logic                accept;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;
  logic                sel_oor;
  logic                access_c;
  logic [NPORTS-1:0]   req_ready_c;
  logic [NPORTS-1:0]   rsp_valid_c;

  rr_arb2 u_rr_arb2 (
    .valid_i      (bus.req_valid),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  assign sel_we    = bus.req_we[gnt_idx];
  assign sel_addr  = gnt_idx ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
  assign sel_wdata = gnt_idx ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
  assign sel_be    = gnt_idx ? bus.req_be[2*BE_W-1:BE_W]        : bus.req_be[BE_W-1:0];
  assign sel_oor   = addr_out_of_range(sel_addr);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          accept  = 1'b1;
          state_d = sel_oor ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_DMA;
      owner_q      <= PORT_CPU;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      be_q         <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= gnt_idx;
        last_grant_q <= gnt_idx;
        we_q         <= sel_we;
        addr_q       <= sel_addr;
        wdata_q      <= sel_wdata;
        be_q         <= sel_be;
        err_q        <= sel_oor;
        rdata_q      <= '0;
      end
      if (state_q == ST_ACCESS) begin
        rdata_q <= we_q ? '0 : bus.mem_data_out;
        err_q   <= 1'b0;
      end
    end
  end

  // Strobes are gated by rst so a reset landing in ACCESS suppresses the write.
  always_comb begin
    access_c    = (state_q == ST_ACCESS) && !rst;
    req_ready_c = '0;
    rsp_valid_c = '0;
    if (!rst && state_q == ST_IDLE && gnt_valid) req_ready_c[gnt_idx] = 1'b1;
    if (!rst && state_q == ST_RESP)              rsp_valid_c[owner_q] = 1'b1;
  end

  assign bus.req_ready       = req_ready_c;
  assign bus.rsp_valid       = rsp_valid_c;
  assign bus.rsp_rdata       = rdata_q;
  assign bus.rsp_err         = err_q;
  assign bus.mem_read        = access_c & ~we_q;
  assign bus.mem_write       = access_c & we_q;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_write_data  = wdata_q;
  assign bus.mem_byte_enable = access_c ? be_q : '0;
  assign state_o             = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random two-port traffic,
// checked against a byte-array reference memory through per-port expected queues.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned LAST_OK = 1020;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  dmem_if bus();
  state_e state;

  dmem_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  logic        p_valid [2] = '{1'b0, 1'b0};
  logic        p_we    [2] = '{1'b0, 1'b0};
  logic [31:0] p_addr  [2] = '{32'h0, 32'h0};
  logic [31:0] p_wdata [2] = '{32'h0, 32'h0};
  logic [3:0]  p_be    [2] = '{4'h0, 4'h0};
  logic [1:0]  rsp_rdy = 2'b00;
  bit          rsp_hold = 1'b0;

  assign bus.req_valid = {p_valid[1], p_valid[0]};
  assign bus.req_we    = {p_we[1], p_we[0]};
  assign bus.req_addr  = {p_addr[1], p_addr[0]};
  assign bus.req_wdata = {p_wdata[1], p_wdata[0]};
  assign bus.req_be    = {p_be[1], p_be[0]};
  assign bus.rsp_ready = rsp_rdy;

  always @(posedge clk) begin
    #1;
    rsp_rdy = rsp_hold ? 2'b00 : 2'($urandom_range(0, 3));
  end

  // ---------------- memory attached to the DUT ----------------
  logic [7:0] phys [0:1023] = '{default: 8'h00};
  logic [9:0] ma;
  assign ma = bus.mem_addr[9:0];

  always_comb begin
    bus.mem_data_out = '0;
    if (bus.mem_addr <= 32'(LAST_OK))
      bus.mem_data_out = {phys[ma + 10'd3], phys[ma + 10'd2], phys[ma + 10'd1], phys[ma]};
  end

  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr <= 32'(LAST_OK))
      for (int i = 0; i < 4; i++)
        if (bus.mem_byte_enable[i]) phys[ma + 10'(i)] <= bus.mem_write_data[8*i +: 8];
  end

  // ---------------- scoreboard state ----------------
  logic [7:0]  ref_mem [0:1023] = '{default: 8'h00};
  logic [32:0] exp_q_cpu [$];
  logic [32:0] exp_q_dma [$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_wr   = 0;
  int exp_rd   = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: {err, rdata} for one transaction, updating ref_mem on writes.
  task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, output logic [32:0] rsp);
    logic [9:0] b;
    b = a[9:0];
    if (a > 32'(LAST_OK)) begin
      rsp = {1'b1, 32'h0};
    end else if (we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[b + 10'(i)] = d[8*i +: 8];
      rsp = 33'h0;
      exp_wr++;
    end else begin
      rsp = {1'b0, ref_mem[b + 10'd3], ref_mem[b + 10'd2], ref_mem[b + 10'd1], ref_mem[b]};
      exp_rd++;
    end
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_req(input int p, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input bit keep);
    bit got;
    logic [32:0] e;
    p_we[p] = we; p_addr[p] = a; p_wdata[p] = d; p_be[p] = be; p_valid[p] = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 400 && !got; w++) begin
      @(negedge clk);
      if (bus.req_ready[p]) got = 1'b1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL req_accept_timeout: port %0d addr 0x%0h never accepted, required accept", p, a);
      p_valid[p] = 1'b0;
      return;
    end
    if (keep) begin
      model_access(we, a, d, be, e);
      if (p == 0) exp_q_cpu.push_back(e); else exp_q_dma.push_back(e);
    end
    @(posedge clk); #1;
    p_valid[p] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (exp_q_cpu.size() == 0 && exp_q_dma.size() == 0 && bus.rsp_valid == 2'b00 && state == ST_IDLE)
        done = 1'b1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: cpu_q=%0d dma_q=%0d still pending, required 0", exp_q_cpu.size(), exp_q_dma.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0: case ($urandom_range(0, 3))
           0:       return 32'h3FD;
           1:       return 32'h3FE;
           2:       return 32'h400;
           default: return 32'hFFFF_FFFC;
         endcase
      1:       return 32'h3FC;
      default: return 32'($urandom_range(0, 64));
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic        last_m = 1'b1;
  logic        g_m;
  logic [1:0]  er_m;
  logic [31:0] ga_m;
  int          pend_cyc = 0;
  bit          pend_valid = 1'b0;
  logic [1:0]  prev_rv = 2'b00;
  logic [34:0] prev_vec = '0;
  bit          prev_hs = 1'b0;
  logic        o_m;
  logic [32:0] e_m;

  always @(negedge clk) begin
    if (bus.mem_write) wr_cnt++;
    if (bus.mem_read)  rd_cnt++;
    if (!bus.mem_write && !bus.mem_read) check("be_idle", 64'(bus.mem_byte_enable), 64'd0);
    if (rst) begin
      last_m = 1'b1; pend_valid = 1'b0; prev_rv = 2'b00; prev_hs = 1'b0;
    end else begin
      if (bus.req_ready != 2'b00) begin
        g_m  = (bus.req_valid == 2'b11) ? ~last_m : bus.req_valid[1];
        er_m = (bus.req_valid == 2'b00) ? 2'b00 : (g_m ? 2'b10 : 2'b01);
        check("grant", 64'(bus.req_ready), 64'(er_m));
        last_m     = g_m;
        ga_m       = g_m ? bus.req_addr[63:32] : bus.req_addr[31:0];
        pend_cyc   = cyc + ((ga_m > 32'(LAST_OK)) ? 1 : 2);
        pend_valid = 1'b1;
      end
      if (bus.rsp_valid != 2'b00) begin
        check("no_req_ready_in_rsp", 64'(bus.req_ready), 64'd0);
        check("rsp_onehot", 64'($onehot(bus.rsp_valid)), 64'd1);
        o_m = bus.rsp_valid[1];
        if (prev_rv == 2'b00) begin
          check("rsp_latency", 64'(cyc), pend_valid ? 64'(pend_cyc) : 64'hFFFF_FFFF);
          pend_valid = 1'b0;
        end else if (!prev_hs) begin
          check("rsp_hold_stable", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 64'(prev_vec));
        end
        if (bus.rsp_ready[o_m]) begin
          if ((o_m ? exp_q_dma.size() : exp_q_cpu.size()) == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_rsp: port %0d got err=%0b rdata=0x%0h, required no response", o_m, bus.rsp_err, bus.rsp_rdata);
          end else begin
            e_m = o_m ? exp_q_dma.pop_front() : exp_q_cpu.pop_front();
            check(o_m ? "rsp_dma" : "rsp_cpu", 64'({bus.rsp_err, bus.rsp_rdata}), 64'(e_m));
          end
        end
        prev_hs = bus.rsp_ready[o_m];
      end
      prev_rv  = bus.rsp_valid;
      prev_vec = {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    end
  end

  // ---------------- stimulus ----------------
  int acc_before;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state",     64'(state), 64'(ST_IDLE));
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_mem_strb",  64'({bus.mem_read, bus.mem_write, bus.mem_byte_enable}), 64'd0);
    check("reset_rsp_data",  64'({bus.rsp_err, bus.rsp_rdata}), 64'd0);
    check("reset_mem_addr",  64'({bus.mem_addr, bus.mem_write_data}), 64'd0);
    @(posedge clk); #1;

    // CPU write then read back
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    wait_drain();
    check("t1_write_cycles", 64'(wr_cnt), 64'd1);

    // Contention from reset: CPU first, then alternation
    do_reset();
    fork
      do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      do_req(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1);
    join
    fork
      begin for (int k = 0; k < 4; k++) do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1); end
      begin for (int k = 0; k < 4; k++) do_req(1, 1'b0, 32'h4,  32'h0, 4'h0, 1'b1); end
    join
    wait_drain();

    // DMA partial-lane write
    do_req(1, 1'b1, 32'h20, 32'h1122_3344, 4'b0100, 1'b1);
    do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    wait_drain();

    // Out-of-range read: no memory strobes
    acc_before = wr_cnt + rd_cnt;
    do_req(0, 1'b0, 32'h3FD, 32'h0, 4'h0, 1'b1);
    wait_drain();
    check("t4_no_mem_access", 64'(wr_cnt + rd_cnt), 64'(acc_before));

    // Stall the response; the other port's request must not be taken
    rsp_hold = 1'b1;
    repeat (2) @(posedge clk); #1;
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    p_we[1] = 1'b0; p_addr[1] = 32'h4; p_valid[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1 p_valid[1] = 1'b0;
    @(negedge clk);
    check("t5_held_valid", 64'(bus.rsp_valid), 64'd1);
    @(posedge clk); #1;
    rsp_hold = 1'b0;
    wait_drain();

    // Reset landing in the ACCESS cycle of a write
    do_req(0, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_write_suppressed", 64'({bus.mem_write, bus.mem_read}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_state_idle", 64'(state), 64'(ST_IDLE));
    check("t6_outputs_zero", 64'({bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.mem_byte_enable}), 64'd0);
    check("t6_rdata_zero", 64'(bus.rsp_rdata), 64'd0);
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1);
    wait_drain();

    // Random concurrent traffic on both ports
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          int g;
          g = $urandom_range(0, 3);
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
          do_req(0, 1'($urandom_range(0, 1)), pick_addr(), $urandom, 4'($urandom_range(0, 15)), 1'b1);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          int g;
          g = $urandom_range(0, 3);
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
          do_req(1, 1'($urandom_range(0, 1)), pick_addr(), $urandom, 4'($urandom_range(0, 15)), 1'b1);
        end
      end
    join
    wait_drain();

    check("final_cpu_q_empty", 64'(exp_q_cpu.size()), 64'd0);
    check("final_dma_q_empty", 64'(exp_q_dma.size()), 64'd0);
    check("final_write_cycles", 64'(wr_cnt), 64'(exp_wr));
    check("final_read_cycles",  64'(rd_cnt), 64'(exp_rd));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
